// File: rtl/aead_block_framer.sv
// aead_block_framer: packs an AAD byte stream and then a payload byte stream
// into zero-padded 16-byte Poly1305 blocks, and finishes with the
// {pld_len, aad_len} length block.
module aead_block_framer #(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_BYTES-1:0] in_data,
  input  logic [IN_BYTES-1:0]   in_keep,
  input  logic                  in_last,
  input  logic                  in_is_pld,
  output logic                  aad_valid,
  input  logic                  aad_ready,
  output logic [127:0]          aad_data,
  output logic [15:0]           aad_keep,
  output logic                  pld_valid,
  input  logic                  pld_ready,
  output logic [127:0]          pld_data,
  output logic [15:0]           pld_keep,
  output logic                  len_valid,
  input  logic                  len_ready,
  output logic [127:0]          len_block,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {S_IDLE, S_AAD, S_PLD, S_LEN, S_DONE} state_t;

  localparam logic [IN_BYTES-1:0] KEEP_ONE = IN_BYTES'(1);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [127:0]     buf_q, buf_d;
  logic [4:0]       wp_q, wp_d;
  logic [LEN_W-1:0] aad_len_q, aad_len_d, pld_len_q, pld_len_d;
  logic             aad_valid_q, aad_valid_d, pld_valid_q, pld_valid_d;
  logic [127:0]     aad_data_q, aad_data_d, pld_data_q, pld_data_d;
  logic [15:0]      aad_keep_q, aad_keep_d, pld_keep_q, pld_keep_d;
  logic             len_valid_q, len_valid_d;
  logic [127:0]     len_block_q, len_block_d;
  logic             done_q, done_d, err_q, err_d;

  logic [8*IN_BYTES-1:0] beat_masked;
  logic [127:0]          merged;
  logic [4:0]            cnt, wp_sum;
  logic [15:0]           blk_keep;
  logic                  accept, keep_contig, keep_full, bad_mode, bad, emit;
  logic [63:0]           aad_len64, pld_len64;

  // Disabled byte lanes are forced to zero so padding bytes stay zero.
  for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_mask
    assign beat_masked[8*gi +: 8] = in_keep[gi] ? in_data[8*gi +: 8] : 8'h00;
  end

  // Valid-byte mask of a block holding wp_sum bytes.
  for (genvar gi = 0; gi < 16; gi++) begin : g_keep
    assign blk_keep[gi] = (5'(gi) < wp_sum);
  end

  // Number of enabled bytes in the current beat.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < IN_BYTES; k++) cnt = cnt + 5'(in_keep[k]);
  end

  assign accept      = in_valid && in_ready_q;
  assign keep_contig = ((in_keep & (in_keep + KEEP_ONE)) == '0);
  assign keep_full   = &in_keep;
  assign bad_mode    = (state_q == S_PLD) ? !in_is_pld : in_is_pld;
  assign bad         = !keep_contig || (!keep_full && !in_last) || bad_mode;
  assign wp_sum      = wp_q + cnt;
  assign emit        = (wp_sum == 5'd16) || (in_last && (wp_sum != 5'd0));
  assign merged      = buf_q | (128'(beat_masked) << {wp_q, 3'b000});
  assign aad_len64   = 64'(aad_len_q);
  assign pld_len64   = 64'(pld_len_q);

  // Next-state logic: packing, segment sequencing, handshakes and errors.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wp_d        = wp_q;
    aad_len_d   = aad_len_q;
    pld_len_d   = pld_len_q;
    aad_valid_d = aad_valid_q;
    aad_data_d  = aad_data_q;
    aad_keep_d  = aad_keep_q;
    pld_valid_d = pld_valid_q;
    pld_data_d  = pld_data_q;
    pld_keep_d  = pld_keep_q;
    len_valid_d = len_valid_q;
    len_block_d = len_block_q;
    done_d      = 1'b0;
    err_d       = err_q;
    if (abort) begin
      state_d     = S_IDLE;
      buf_d       = '0;
      wp_d        = '0;
      aad_len_d   = '0;
      pld_len_d   = '0;
      aad_valid_d = 1'b0;
      pld_valid_d = 1'b0;
      len_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (aad_valid_q && aad_ready) aad_valid_d = 1'b0;
      if (pld_valid_q && pld_ready) pld_valid_d = 1'b0;
      case (state_q)
        S_LEN: begin
          if (len_valid_q) begin
            if (len_ready) begin
              len_valid_d = 1'b0;
              state_d     = S_DONE;
              done_d      = 1'b1;
            end
          end else if (!pld_valid_q) begin
            // The length block follows the last payload block out.
            len_valid_d = 1'b1;
            len_block_d = {pld_len64, aad_len64};
          end
        end
        S_DONE: state_d = S_IDLE;
        default: begin
          if (accept) begin
            if (bad) begin
              err_d     = 1'b1;
              state_d   = S_IDLE;
              buf_d     = '0;
              wp_d      = '0;
              aad_len_d = '0;
              pld_len_d = '0;
            end else begin
              if (state_q == S_IDLE) begin
                aad_len_d = LEN_W'(cnt);
                pld_len_d = '0;
              end else if (state_q == S_PLD) begin
                pld_len_d = pld_len_q + LEN_W'(cnt);
              end else begin
                aad_len_d = aad_len_q + LEN_W'(cnt);
              end
              if (emit) begin
                buf_d = '0;
                wp_d  = '0;
                if (state_q == S_PLD) begin
                  pld_valid_d = 1'b1;
                  pld_data_d  = merged;
                  pld_keep_d  = blk_keep;
                end else begin
                  aad_valid_d = 1'b1;
                  aad_data_d  = merged;
                  aad_keep_d  = blk_keep;
                end
              end else begin
                buf_d = merged;
                wp_d  = wp_sum;
              end
              if (in_last) state_d = (state_q == S_PLD) ? S_LEN : S_PLD;
              else if (state_q == S_IDLE) state_d = S_AAD;
            end
          end
        end
      endcase
    end
    // Registered acceptance decision: never depends combinationally on *_ready.
    in_ready_d = ((state_d == S_IDLE) || (state_d == S_AAD) || (state_d == S_PLD)) &&
                 !err_d && !aad_valid_d && !pld_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      buf_q       <= '0;
      wp_q        <= '0;
      aad_len_q   <= '0;
      pld_len_q   <= '0;
      aad_valid_q <= 1'b0;
      aad_data_q  <= '0;
      aad_keep_q  <= '0;
      pld_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pld_keep_q  <= '0;
      len_valid_q <= 1'b0;
      len_block_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      buf_q       <= buf_d;
      wp_q        <= wp_d;
      aad_len_q   <= aad_len_d;
      pld_len_q   <= pld_len_d;
      aad_valid_q <= aad_valid_d;
      aad_data_q  <= aad_data_d;
      aad_keep_q  <= aad_keep_d;
      pld_valid_q <= pld_valid_d;
      pld_data_q  <= pld_data_d;
      pld_keep_q  <= pld_keep_d;
      len_valid_q <= len_valid_d;
      len_block_q <= len_block_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign aad_valid = aad_valid_q;
  assign aad_data  = aad_data_q;
  assign aad_keep  = aad_keep_q;
  assign pld_valid = pld_valid_q;
  assign pld_data  = pld_data_q;
  assign pld_keep  = pld_keep_q;
  assign len_valid = len_valid_q;
  assign len_block = len_block_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aead_block_framer.sv
// Testbench for aead_block_framer: 4-, 8- and 16-byte instances, table-driven
// vectors for the 4-byte datapath plus directed multi-cycle sequences.
module tb_aead_block_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- IN_BYTES = 4 ----------------
  logic abort_4, in_valid_4, in_ready_4, in_last_4, in_is_pld_4;
  logic [31:0] in_data_4;
  logic [3:0] in_keep_4;
  logic aad_valid_4, aad_ready_4, pld_valid_4, pld_ready_4, len_valid_4, len_ready_4;
  logic busy_4, done_4, err_4;
  logic [127:0] aad_data_4, pld_data_4, len_block_4;
  logic [15:0] aad_keep_4, pld_keep_4;

  aead_block_framer #(.IN_BYTES(4), .LEN_W(32)) u4 (
    .clk(clk), .rst(rst), .abort(abort_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_data(in_data_4), .in_keep(in_keep_4), .in_last(in_last_4), .in_is_pld(in_is_pld_4),
    .aad_valid(aad_valid_4), .aad_ready(aad_ready_4), .aad_data(aad_data_4), .aad_keep(aad_keep_4),
    .pld_valid(pld_valid_4), .pld_ready(pld_ready_4), .pld_data(pld_data_4), .pld_keep(pld_keep_4),
    .len_valid(len_valid_4), .len_ready(len_ready_4), .len_block(len_block_4),
    .busy(busy_4), .done(done_4), .err(err_4));

  // ---------------- IN_BYTES = 8 ----------------
  logic abort_8, in_valid_8, in_ready_8, in_last_8, in_is_pld_8;
  logic [63:0] in_data_8;
  logic [7:0] in_keep_8;
  logic aad_valid_8, aad_ready_8, pld_valid_8, pld_ready_8, len_valid_8, len_ready_8;
  logic busy_8, done_8, err_8;
  logic [127:0] aad_data_8, pld_data_8, len_block_8;
  logic [15:0] aad_keep_8, pld_keep_8;

  aead_block_framer #(.IN_BYTES(8), .LEN_W(32)) u8 (
    .clk(clk), .rst(rst), .abort(abort_8), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in_data(in_data_8), .in_keep(in_keep_8), .in_last(in_last_8), .in_is_pld(in_is_pld_8),
    .aad_valid(aad_valid_8), .aad_ready(aad_ready_8), .aad_data(aad_data_8), .aad_keep(aad_keep_8),
    .pld_valid(pld_valid_8), .pld_ready(pld_ready_8), .pld_data(pld_data_8), .pld_keep(pld_keep_8),
    .len_valid(len_valid_8), .len_ready(len_ready_8), .len_block(len_block_8),
    .busy(busy_8), .done(done_8), .err(err_8));

  // ---------------- IN_BYTES = 16 ----------------
  logic abort_16, in_valid_16, in_ready_16, in_last_16, in_is_pld_16;
  logic [127:0] in_data_16;
  logic [15:0] in_keep_16;
  logic aad_valid_16, aad_ready_16, pld_valid_16, pld_ready_16, len_valid_16, len_ready_16;
  logic busy_16, done_16, err_16;
  logic [127:0] aad_data_16, pld_data_16, len_block_16;
  logic [15:0] aad_keep_16, pld_keep_16;

  aead_block_framer #(.IN_BYTES(16), .LEN_W(32)) u16 (
    .clk(clk), .rst(rst), .abort(abort_16), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .in_data(in_data_16), .in_keep(in_keep_16), .in_last(in_last_16), .in_is_pld(in_is_pld_16),
    .aad_valid(aad_valid_16), .aad_ready(aad_ready_16), .aad_data(aad_data_16), .aad_keep(aad_keep_16),
    .pld_valid(pld_valid_16), .pld_ready(pld_ready_16), .pld_data(pld_data_16), .pld_keep(pld_keep_16),
    .len_valid(len_valid_16), .len_ready(len_ready_16), .len_block(len_block_16),
    .busy(busy_16), .done(done_16), .err(err_16));

  // Handshake monitors: valid && ready seen at the negedge completes at the next posedge.
  int n_aad4 = 0, n_pld4 = 0, n_done4 = 0, n_aad16 = 0;
  logic [127:0] q8_data[$];
  logic [15:0]  q8_keep[$];
  always @(negedge clk) begin
    if (aad_valid_4 && aad_ready_4) n_aad4 <= n_aad4 + 1;
    if (pld_valid_4 && pld_ready_4) n_pld4 <= n_pld4 + 1;
    if (done_4) n_done4 <= n_done4 + 1;
    if (aad_valid_16 && aad_ready_16) n_aad16 <= n_aad16 + 1;
    if (pld_valid_8 && pld_ready_8) begin
      q8_data.push_back(pld_data_8);
      q8_keep.push_back(pld_keep_8);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout, expected event within bound", name);
  endtask

  task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l, input logic p);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data_4 = d; in_keep_4 = k; in_last_4 = l; in_is_pld_4 = p; in_valid_4 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_4) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    else tmo("send4 in_ready");
    #1 in_valid_4 = 1'b0;
  endtask

  task automatic send8(input logic [63:0] d, input logic [7:0] k, input logic l, input logic p);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data_8 = d; in_keep_8 = k; in_last_8 = l; in_is_pld_8 = p; in_valid_8 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_8) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    else tmo("send8 in_ready");
    #1 in_valid_8 = 1'b0;
  endtask

  task automatic send16(input logic [127:0] d, input logic [15:0] k, input logic l, input logic p);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data_16 = d; in_keep_16 = k; in_last_16 = l; in_is_pld_16 = p; in_valid_16 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_16) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    else tmo("send16 in_ready");
    #1 in_valid_16 = 1'b0;
  endtask

  // Vector table for the 4-byte datapath.
  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        pld;
    logic        exp_aad;
    logic        exp_pld;
    logic [127:0] exp_data;
    logic [15:0] exp_keep;
    logic        exp_err;
  } vec_t;
  vec_t tbl[9];

  function automatic void set_vec(input int i, input string n, input logic [31:0] d,
                                  input logic [3:0] k, input logic l, input logic p,
                                  input logic ea, input logic ep, input logic [127:0] ed,
                                  input logic [15:0] ek, input logic ee);
    tbl[i].name = n; tbl[i].data = d; tbl[i].keep = k; tbl[i].last = l; tbl[i].pld = p;
    tbl[i].exp_aad = ea; tbl[i].exp_pld = ep; tbl[i].exp_data = ed; tbl[i].exp_keep = ek;
    tbl[i].exp_err = ee;
  endfunction

  task automatic apply4(input int i);
    send4(tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].pld);
    @(negedge clk);
    chk({tbl[i].name, " aad_valid"}, aad_valid_4, tbl[i].exp_aad);
    chk({tbl[i].name, " pld_valid"}, pld_valid_4, tbl[i].exp_pld);
    chk({tbl[i].name, " err"}, err_4, tbl[i].exp_err);
    if (tbl[i].exp_aad) begin
      chk({tbl[i].name, " aad_data"}, aad_data_4, tbl[i].exp_data);
      chk({tbl[i].name, " aad_keep"}, aad_keep_4, tbl[i].exp_keep);
    end
    if (tbl[i].exp_pld) begin
      chk({tbl[i].name, " pld_data"}, pld_data_4, tbl[i].exp_data);
      chk({tbl[i].name, " pld_keep"}, pld_keep_4, tbl[i].exp_keep);
    end
    if (tbl[i].exp_err) chk({tbl[i].name, " in_ready"}, in_ready_4, 1'b0);
  endtask

  logic [127:0] held_d;
  logic [15:0]  held_k;
  bit           held_seen;
  bit           found;
  logic [127:0] exp_blk;
  logic [63:0]  beat8;

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    abort_4 = 0; in_valid_4 = 0; in_data_4 = '0; in_keep_4 = '0; in_last_4 = 0; in_is_pld_4 = 0;
    abort_8 = 0; in_valid_8 = 0; in_data_8 = '0; in_keep_8 = '0; in_last_8 = 0; in_is_pld_8 = 0;
    abort_16 = 0; in_valid_16 = 0; in_data_16 = '0; in_keep_16 = '0; in_last_16 = 0; in_is_pld_16 = 0;
    aad_ready_4 = 1; pld_ready_4 = 1; len_ready_4 = 1;
    aad_ready_8 = 1; pld_ready_8 = 1; len_ready_8 = 1;
    aad_ready_16 = 1; pld_ready_16 = 1; len_ready_16 = 1;

    set_vec(0, "aad0", 32'h03020100, 4'hf, 0, 0, 0, 0, '0, '0, 0);
    set_vec(1, "aad1", 32'h07060504, 4'hf, 0, 0, 0, 0, '0, '0, 0);
    set_vec(2, "aad2", 32'h0b0a0908, 4'hf, 1, 0, 1, 0,
            128'h00000000_0b0a0908_07060504_03020100, 16'h0fff, 0);
    set_vec(3, "pld0", 32'h13121110, 4'hf, 0, 1, 0, 0, '0, '0, 0);
    set_vec(4, "pld1", 32'h17161514, 4'hf, 0, 1, 0, 0, '0, '0, 0);
    set_vec(5, "pld2", 32'h1b1a1918, 4'hf, 0, 1, 0, 0, '0, '0, 0);
    set_vec(6, "pld3", 32'h1f1e1d1c, 4'hf, 0, 1, 0, 1,
            128'h1f1e1d1c_1b1a1918_17161514_13121110, 16'hffff, 0);
    set_vec(7, "pld4", 32'h23222120, 4'hf, 1, 1, 0, 1,
            128'h00000000_00000000_00000000_23222120, 16'h000f, 0);
    set_vec(8, "keep5", 32'h44332211, 4'h5, 1, 0, 0, 0, '0, '0, 1);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst in_ready_4", in_ready_4, 1'b0);
    chk("rst busy_4", busy_4, 1'b0);
    chk("rst err_4", err_4, 1'b0);
    chk("rst aad_valid_4", aad_valid_4, 1'b0);
    chk("rst pld_valid_4", pld_valid_4, 1'b0);
    chk("rst len_valid_4", len_valid_4, 1'b0);
    chk("rst len_block_4", len_block_4, '0);
    chk("rst done_4", done_4, 1'b0);
    chk("rst in_ready_16", in_ready_16, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // 12-byte AAD + 20-byte payload on the 4-byte datapath
    for (int i = 0; i < 8; i++) apply4(i);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (len_valid_4) begin found = 1'b1; break; end
    end
    if (!found) tmo("len_valid_4");
    chk("len_block_4", len_block_4, 128'h0000000000000014_000000000000000c);
    @(negedge clk);
    chk("done_4 pulse", done_4, 1'b1);
    @(negedge clk);
    chk("done_4 after pulse", done_4, 1'b0);
    chk("busy_4 idle", busy_4, 1'b0);
    chk("in_ready_4 idle", in_ready_4, 1'b1);

    // Non-contiguous keep with last
    apply4(8);
    chk("keep5 no aad block", n_aad4, 1);

    // abort clears the error
    @(posedge clk); #1 abort_4 = 1'b1;
    @(posedge clk); #1 abort_4 = 1'b0;
    @(negedge clk);
    chk("abort1 err_4", err_4, 1'b0);
    chk("abort1 in_ready_4", in_ready_4, 1'b1);

    // Payload beat sent first from IDLE
    send4(32'haabbccdd, 4'hf, 1'b0, 1'b1);
    @(negedge clk);
    chk("pldfirst err_4", err_4, 1'b1);
    chk("pldfirst aad_valid_4", aad_valid_4, 1'b0);
    chk("pldfirst pld_valid_4", pld_valid_4, 1'b0);
    chk("pldfirst in_ready_4", in_ready_4, 1'b0);
    @(posedge clk); #1 abort_4 = 1'b1;
    @(posedge clk); #1 abort_4 = 1'b0;
    @(negedge clk);
    chk("abort2 err_4", err_4, 1'b0);
    chk("abort2 in_ready_4", in_ready_4, 1'b1);
    chk("abort2 busy_4", busy_4, 1'b0);
    chk("u4 aad block count", n_aad4, 1);
    chk("u4 pld block count", n_pld4, 2);
    chk("u4 done count", n_done4, 1);

    // 16-byte datapath: empty AAD, one full payload beat
    send16('0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("emptyaad aad_valid_16", aad_valid_16, 1'b0);
    chk("emptyaad err_16", err_16, 1'b0);
    chk("emptyaad in_ready_16", in_ready_16, 1'b1);
    send16(128'hffeeddccbbaa99887766554433221100, 16'hffff, 1'b1, 1'b1);
    @(negedge clk);
    chk("p16 pld_valid", pld_valid_16, 1'b1);
    chk("p16 pld_data", pld_data_16, 128'hffeeddccbbaa99887766554433221100);
    chk("p16 pld_keep", pld_keep_16, 16'hffff);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (len_valid_16) begin found = 1'b1; break; end
    end
    if (!found) tmo("len_valid_16");
    chk("len_block_16 empty aad", len_block_16, 128'h0000000000000010_0000000000000000);
    repeat (3) @(negedge clk);
    chk("u16 no aad block", n_aad16, 0);
    chk("u16 idle after done", busy_16, 1'b0);

    // 8-byte datapath: 8-byte AAD then 48-byte payload with a 10-cycle stall
    send8(64'h0706050403020100, 8'hff, 1'b1, 1'b0);
    @(negedge clk);
    chk("a8 aad_valid", aad_valid_8, 1'b1);
    chk("a8 aad_data", aad_data_8, 128'h0706050403020100);
    chk("a8 aad_keep", aad_keep_8, 16'h00ff);
    held_seen = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          for (int j = 0; j < 8; j++) beat8[8*j +: 8] = 8'h40 + 8'(8*b + j);
          send8(beat8, 8'hff, (b == 5), 1'b1);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 pld_ready_8 = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (pld_valid_8) begin
            chk("stall in_ready_8", in_ready_8, 1'b0);
            if (!held_seen) begin
              held_d = pld_data_8;
              held_k = pld_keep_8;
              held_seen = 1'b1;
            end else begin
              chk("stall pld_data_8 stable", pld_data_8, held_d);
              chk("stall pld_keep_8 stable", pld_keep_8, held_k);
            end
          end
        end
        @(posedge clk); #1 pld_ready_8 = 1'b1;
      end
    join
    chk("stall saw pending block", held_seen, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (len_valid_8) begin found = 1'b1; break; end
    end
    if (!found) tmo("len_valid_8");
    chk("len_block_8", len_block_8, 128'h0000000000000030_0000000000000008);
    chk("u8 pld block count", q8_data.size(), 3);
    for (int k = 0; k < 3 && k < q8_data.size(); k++) begin
      for (int j = 0; j < 16; j++) exp_blk[8*j +: 8] = 8'h40 + 8'(16*k + j);
      chk($sformatf("u8 pld block %0d data", k), q8_data[k], exp_blk);
      chk($sformatf("u8 pld block %0d keep", k), q8_keep[k], 16'hffff);
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset while a payload block is pending
    pld_ready_16 = 1'b0;
    send16(128'h0f0e0d0c0b0a09080706050403020100, 16'hffff, 1'b1, 1'b0);
    send16(128'h1f1e1d1c1b1a19181716151413121110, 16'hffff, 1'b1, 1'b1);
    @(negedge clk);
    chk("prerst pld_valid_16", pld_valid_16, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("asyncrst pld_valid_16", pld_valid_16, 1'b0);
    chk("asyncrst pld_data_16", pld_data_16, '0);
    chk("asyncrst pld_keep_16", pld_keep_16, '0);
    chk("asyncrst aad_data_16", aad_data_16, '0);
    chk("asyncrst in_ready_16", in_ready_16, 1'b0);
    chk("asyncrst busy_16", busy_16, 1'b0);
    @(posedge clk); #1 rst = 1'b0; pld_ready_16 = 1'b1;
    send16(128'h2f2e2d2c2b2a29282726252423222120, 16'hffff, 1'b1, 1'b0);
    @(negedge clk);
    chk("post aad_data_16", aad_data_16, 128'h2f2e2d2c2b2a29282726252423222120);
    chk("post aad_keep_16", aad_keep_16, 16'hffff);
    send16(128'h3f3e3d3c3b3a39383736353433323130, 16'hffff, 1'b1, 1'b1);
    @(negedge clk);
    chk("post pld_data_16", pld_data_16, 128'h3f3e3d3c3b3a39383736353433323130);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (len_valid_16) begin found = 1'b1; break; end
    end
    if (!found) tmo("post len_valid_16");
    chk("post len_block_16", len_block_16, 128'h0000000000000010_0000000000000010);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_16) begin found = 1'b1; break; end
    end
    if (!found) tmo("post done_16");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
